// File: rtl/dmem_bus_fabric.sv
// dmem_bus_fabric
//   Data-memory interconnect between the cpu dmem port and N_SLAVES
//   memory-mapped slaves. Each slave owns a base/mask window. Requests are
//   latched and issued to the selected slave as a one-cycle strobe. The fabric
//   then waits for that slave's ready, or gives up after TIMEOUT cycles, and
//   answers the cpu with a one-cycle dmem_ready pulse. The first unmapped or
//   timed-out access is captured in the err_* registers until err_clr.
//
//   Handshake: the cpu holds dmem_read/dmem_writeb/dmem_addr/dmem_wdata stable
//   until it sees dmem_ready=1. dmem_ready is high for exactly one cycle, with
//   dmem_rdata valid in that cycle. The fabric pulses s_read[i] or s_writeb[i]
//   for exactly one cycle. It then takes the first cycle with s_ready[i]=1 as
//   completion and samples s_rdata[i] in that cycle. Ready from any
//   non-selected slave is ignored.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   dmem_*         cpu side: writeb/read/addr/wdata in, rdata/ready out
//   s_writeb       N*4 per-slave byte enables (field i for slave i)
//   s_read         N per-slave read strobes
//   s_addr/s_wdata latched address / write data shared by all slaves
//   s_rdata        N*32 per-slave read data
//   s_ready        N per-slave completion
//   err_valid      sticky error flag; err_timeout = kind; err_addr = address
//   err_clr        clears the error registers (a same-cycle new error wins)
//   dbg_state      current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
module dmem_bus_fabric #(
  parameter int unsigned             N_SLAVES      = 4,
  parameter logic [N_SLAVES*32-1:0]  BASE          = '0,
  parameter logic [N_SLAVES*32-1:0]  MASK          = '1,
  parameter int unsigned             TIMEOUT       = 255,
  parameter logic [31:0]             UNMAPPED_DATA = 32'hfefefefe,
  parameter logic [31:0]             TIMEOUT_DATA  = 32'hfdfdfdfd
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               dmem_writeb,
  input  logic                     dmem_read,
  input  logic [31:0]              dmem_addr,
  input  logic [31:0]              dmem_wdata,
  output logic [31:0]              dmem_rdata,
  output logic                     dmem_ready,
  output logic [N_SLAVES*4-1:0]    s_writeb,
  output logic [N_SLAVES-1:0]      s_read,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [N_SLAVES*32-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]      s_ready,
  output logic                     err_valid,
  output logic                     err_timeout,
  output logic [31:0]              err_addr,
  input  logic                     err_clr,
  output logic [1:0]               dbg_state
);

  localparam int unsigned SEL_W      = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         writeb_q, writeb_d;
  logic               read_q, read_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_valid_q, err_valid_d;
  logic               err_timeout_q, err_timeout_d;
  logic [31:0]        err_addr_q, err_addr_d;

  logic               req;
  logic               hit_any;
  logic [SEL_W-1:0]   hit_idx;
  logic               sel_ready;
  logic [31:0]        sel_rdata;
  logic               err_new;
  logic               err_new_to;
  logic [31:0]        err_new_addr;

  assign req = dmem_read | (|dmem_writeb);

  // Walk from the highest index down, so the lowest-index hit is the last
  // assignment and wins when windows overlap.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((dmem_addr & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) begin
        hit_any = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  // Response mux for the selected slave only.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*32 +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      writeb_q      <= '0;
      read_q        <= 1'b0;
      sel_q         <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      err_valid_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      writeb_q      <= writeb_d;
      read_q        <= read_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      err_valid_q   <= err_valid_d;
      err_timeout_q <= err_timeout_d;
      err_addr_q    <= err_addr_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    writeb_d     = writeb_q;
    read_d       = read_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_new      = 1'b0;
    err_new_to   = 1'b0;
    err_new_addr = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d   = dmem_addr;
          wdata_d  = dmem_wdata;
          writeb_d = dmem_writeb;
          // A combined read+write is treated as a write only.
          read_d   = dmem_read & ~(|dmem_writeb);
          sel_d    = hit_idx;
          if (hit_any) begin
            state_d = ST_ISSUE;
          end else begin
            rdata_d      = UNMAPPED_DATA;
            err_new      = 1'b1;
            err_new_addr = dmem_addr;
            state_d      = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sel_ready) begin
          rdata_d = (|writeb_q) ? 32'h0 : sel_rdata;
          state_d = ST_RESP;
        end else if (cnt_q == TIMEOUT_M1) begin
          rdata_d    = TIMEOUT_DATA;
          err_new    = 1'b1;
          err_new_to = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        // The request still visible here is the one just answered.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture only the first error. A new error in the same cycle as
    // err_clr replaces the cleared contents.
    err_valid_d   = err_valid_q;
    err_timeout_d = err_timeout_q;
    err_addr_d    = err_addr_q;
    if (err_new && (!err_valid_q || err_clr)) begin
      err_valid_d   = 1'b1;
      err_timeout_d = err_new_to;
      err_addr_d    = err_new_addr;
    end else if (err_clr) begin
      err_valid_d   = 1'b0;
      err_timeout_d = 1'b0;
      err_addr_d    = '0;
    end
  end

  // Outputs.
  always_comb begin
    s_read   = '0;
    s_writeb = '0;
    if (state_q == ST_ISSUE) begin
      for (int i = 0; i < N_SLAVES; i++) begin
        if (sel_q == SEL_W'(i)) begin
          s_read[i]         = read_q;
          s_writeb[i*4 +: 4] = writeb_q;
        end
      end
    end
    dmem_ready  = (state_q == ST_RESP);
    dmem_rdata  = rdata_q;
    s_addr      = addr_q;
    s_wdata     = wdata_q;
    err_valid   = err_valid_q;
    err_timeout = err_timeout_q;
    err_addr    = err_addr_q;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_dmem_bus_fabric.sv
module tb_dmem_bus_fabric;

  localparam int N = 4;
  // Slave 3 window overlaps slave 0 at low addresses; slave 0 must win.
  localparam logic [N*32-1:0] BASE = {32'h0000_0000, 32'h4000_0000, 32'hffff_0700, 32'h0000_0000};
  localparam logic [N*32-1:0] MASK = {32'hfff0_0000, 32'hffff_0000, 32'hffff_ff00, 32'hffff_0000};

  logic              clk;
  logic              rst_n;
  logic [3:0]        dmem_writeb;
  logic              dmem_read;
  logic [31:0]       dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ready;
  logic [N*4-1:0]    s_writeb;
  logic [N-1:0]      s_read;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [N*32-1:0]   s_rdata;
  logic [N-1:0]      s_ready;
  logic              err_valid;
  logic              err_timeout;
  logic [31:0]       err_addr;
  logic              err_clr;
  logic [1:0]        dbg_state;

  logic              s2_ready;
  logic              s2_late;
  int                s2_delay;
  int                s2_pend;

  logic [31:0]       exp_q[$];
  int                n_checks;
  int                n_fail;
  int                resp_cnt;
  int                strobe_cnt;
  logic [N-1:0]      last_sread;
  logic [N*4-1:0]    last_swb;
  logic [31:0]       last_saddr;
  logic [31:0]       last_swdata;

  assign s_rdata = {32'hd3d3d3d3, 32'hc2c2c2c2, 32'ha1a1a1a1, 32'h12345678};
  assign s_ready = {1'b1, s2_ready | s2_late, 1'b1, 1'b1};

  dmem_bus_fabric #(
    .N_SLAVES (N),
    .BASE     (BASE),
    .MASK     (MASK),
    .TIMEOUT  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dmem_writeb (dmem_writeb),
    .dmem_read   (dmem_read),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ready  (dmem_ready),
    .s_writeb    (s_writeb),
    .s_read      (s_read),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_rdata     (s_rdata),
    .s_ready     (s_ready),
    .err_valid   (err_valid),
    .err_timeout (err_timeout),
    .err_addr    (err_addr),
    .err_clr     (err_clr),
    .dbg_state   (dbg_state)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave 2: answers s_read/s_writeb after s2_delay ready-less WAIT cycles;
  // s2_delay < 0 means it never answers.
  initial begin
    s2_ready = 1'b0;
    s2_pend  = -1;
    forever begin
      @(negedge clk);
      s2_ready = 1'b0;
      if (s2_pend == 0) begin
        s2_ready = 1'b1;
        s2_pend  = -1;
      end else if (s2_pend > 0) begin
        s2_pend--;
      end
      if ((s_read[2] || (s_writeb[11:8] != 4'b0)) && s2_delay >= 0) s2_pend = s2_delay;
    end
  end

  // Strobe monitor: counts strobe cycles and records the last one.
  initial begin
    strobe_cnt = 0;
    forever begin
      @(negedge clk);
      if (s_read != '0 || s_writeb != '0) begin
        strobe_cnt++;
        last_sread  = s_read;
        last_swb    = s_writeb;
        last_saddr  = s_addr;
        last_swdata = s_wdata;
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    resp_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n && dmem_ready) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: got rdata %h with no access outstanding", dmem_rdata);
        end else begin
          check("rdata", dmem_rdata, exp_q.pop_front());
        end
      end
    end
  end

  // Driver: called just after a negedge in an IDLE cycle; returns just after
  // the negedge of the following IDLE cycle.
  task automatic access(input logic rd, input logic [3:0] wb, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input int exp_cycles, input int exp_strobes,
                        input logic [N-1:0] exp_sread, input logic [N*4-1:0] exp_swb,
                        input logic clr);
    int lat;
    int s0;
    s0 = strobe_cnt;
    exp_q.push_back(exp_rdata);
    dmem_read   = rd;
    dmem_writeb = wb;
    dmem_addr   = addr;
    dmem_wdata  = wdata;
    err_clr     = clr;
    lat = 0;
    do begin
      @(negedge clk);
      err_clr = 1'b0;
      lat++;
    end while (!dmem_ready && lat < 400);
    if (!dmem_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got no dmem_ready after %0d cycles for addr %h", lat, addr);
      void'(exp_q.pop_back());
    end else begin
      check("latency", 32'(lat + 1), 32'(exp_cycles));
    end
    dmem_read   = 1'b0;
    dmem_writeb = 4'b0;
    @(negedge clk);
    check("strobe_cycles", 32'(strobe_cnt - s0), 32'(exp_strobes));
    if (exp_strobes > 0) begin
      check("s_read", 32'(last_sread), 32'(exp_sread));
      check("s_writeb", 32'(last_swb), 32'(exp_swb));
      check("s_addr", last_saddr, addr);
      check("s_wdata", last_swdata, wdata);
    end
  endtask

  task automatic check_err(input logic v, input logic to, input logic [31:0] a);
    check("err_valid", 32'(err_valid), 32'(v));
    check("err_timeout", 32'(err_timeout), 32'(to));
    check("err_addr", err_addr, a);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(dmem_ready), 32'h0);
    check({tag, "_rdata"}, dmem_rdata, 32'h0);
    check({tag, "_s_read"}, 32'(s_read), 32'h0);
    check({tag, "_s_writeb"}, 32'(s_writeb), 32'h0);
    check({tag, "_s_addr"}, s_addr, 32'h0);
    check({tag, "_s_wdata"}, s_wdata, 32'h0);
    check({tag, "_err_valid"}, 32'(err_valid), 32'h0);
    check({tag, "_err_addr"}, err_addr, 32'h0);
  endtask

  initial begin
    int r0;
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    dmem_read   = 1'b0;
    dmem_writeb = 4'b0;
    dmem_addr   = '0;
    dmem_wdata  = '0;
    err_clr     = 1'b0;
    s2_late     = 1'b0;
    s2_delay    = -1;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Mapped read, slave 0 (also inside slave 3's window: slave 0 wins).
    access(1'b1, 4'b0000, 32'h0000_0010, 32'h0, 32'h12345678, 4, 1, 4'b0001, 16'h0000, 1'b0);
    // Partial write to slave 1.
    access(1'b0, 4'b0011, 32'hffff_0704, 32'hcafebabe, 32'h0, 4, 1, 4'b0000, 16'h0030, 1'b0);
    // Address only slave 3 decodes.
    access(1'b1, 4'b0000, 32'h0005_0000, 32'h0, 32'hd3d3d3d3, 4, 1, 4'b1000, 16'h0000, 1'b0);
    // Read and write together: write only.
    access(1'b1, 4'b1111, 32'h0006_0000, 32'h55aa_33cc, 32'h0, 4, 1, 4'b0000, 16'hf000, 1'b0);
    // Slave 2 answering after three ready-less WAIT cycles.
    s2_delay = 3;
    access(1'b1, 4'b0000, 32'h4000_0100, 32'h0, 32'hc2c2c2c2, 7, 1, 4'b0100, 16'h0000, 1'b0);
    check_err(1'b0, 1'b0, 32'h0);

    // Timeout: slave 2 never answers.
    s2_delay = -1;
    access(1'b1, 4'b0000, 32'h4000_0010, 32'h0, 32'hfdfdfdfd, 11, 1, 4'b0100, 16'h0000, 1'b0);
    check_err(1'b1, 1'b1, 32'h4000_0010);
    // Late ready after the timeout is ignored.
    r0 = resp_cnt;
    s2_late = 1'b1;
    @(negedge clk);
    s2_late = 1'b0;
    repeat (3) @(negedge clk);
    check("late_ready_resp", 32'(resp_cnt), 32'(r0));

    // Clear alone.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check_err(1'b0, 1'b0, 32'h0);

    // Unmapped reads: first error is kept.
    access(1'b1, 4'b0000, 32'h8000_0000, 32'h0, 32'hfefefefe, 2, 0, 4'b0000, 16'h0000, 1'b0);
    check_err(1'b1, 1'b0, 32'h8000_0000);
    access(1'b1, 4'b0000, 32'h9000_0000, 32'h0, 32'hfefefefe, 2, 0, 4'b0000, 16'h0000, 1'b0);
    check_err(1'b1, 1'b0, 32'h8000_0000);
    // Clear together with a new unmapped error: the new error wins.
    access(1'b1, 4'b0000, 32'ha000_0000, 32'h0, 32'hfefefefe, 2, 0, 4'b0000, 16'h0000, 1'b1);
    check_err(1'b1, 1'b0, 32'ha000_0000);
    // Back-to-back mapped read right after an unmapped one.
    access(1'b1, 4'b0000, 32'h0000_0020, 32'h0, 32'h12345678, 4, 1, 4'b0001, 16'h0000, 1'b0);

    // Reset during WAIT: no response for the aborted access.
    r0 = resp_cnt;
    dmem_read = 1'b1;
    dmem_addr = 32'h4000_0040;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    dmem_read = 1'b0;
    rst_n     = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_no_ready", 32'(resp_cnt), 32'(r0));
    access(1'b1, 4'b0000, 32'h0000_0010, 32'h0, 32'h12345678, 4, 1, 4'b0001, 16'h0000, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
